// File: rtl/tile_render_pipe.sv
// Pipelined palette tile renderer: map fetch, glyph fetch, palette lookup.
// Optional TILE_BLINK_EN: index 15 blinks with a vsync-driven frame counter.
module tile_render_pipe #(
    parameter int TILE_LOG2  = 2,
    parameter int MAP_BASE   = 40000,
    parameter int MAP_COLS   = 160,
    parameter int GLYPH_BITS = 6,
    parameter int MEM_LAT    = 1,
    parameter int GLYPH_LAT  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            bright,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic [15:0]                     hCount,
    input  logic [15:0]                     vCount,
    output logic [15:0]                     memAddress,
    input  logic [15:0]                     memData,
    output logic [GLYPH_BITS+2*TILE_LOG2-1:0] glyphAddress,
    input  logic [3:0]                      glyphData,
    input  logic                            pal_we,
    input  logic [3:0]                      pal_idx,
    input  logic [23:0]                     pal_data,
    output logic [7:0]                      VGA_R,
    output logic [7:0]                      VGA_G,
    output logic [7:0]                      VGA_B,
    output logic                            VGA_HS,
    output logic                            VGA_VS,
    output logic                            VGA_BLANK_N
);

    localparam int PW  = 2 * TILE_LOG2;
    localparam int LAT = 3 + MEM_LAT + GLYPH_LAT;

    logic [15:0]               tile_x;
    logic [15:0]               tile_y;
    logic [15:0]               next_addr;
    logic [PW-1:0]             pixpos;
    logic [MEM_LAT:0][PW-1:0]  pix_d;
    logic [LAT-2:0]            bright_d;
    logic [LAT-2:0]            hs_d;
    logic [LAT-2:0]            vs_d;
    logic [23:0]               pal [16];
    logic [23:0]               pal_sel;
    logic [23:0]               rgb;

    function automatic logic [23:0] pal_rst(input int i);
        case (i)
            1:       pal_rst = 24'h0000FF;
            2:       pal_rst = 24'hFFFF00;
            3:       pal_rst = 24'h00A2E6;
            4:       pal_rst = 24'h9CDBE6;
            5:       pal_rst = 24'h7F7F7F;
            default: pal_rst = 24'h000000;
        endcase
    endfunction

    assign tile_x    = hCount >> TILE_LOG2;
    assign tile_y    = vCount >> TILE_LOG2;
    assign next_addr = 16'(MAP_BASE) + tile_x + tile_y * 16'(MAP_COLS);
    assign pixpos    = {vCount[TILE_LOG2-1:0], hCount[TILE_LOG2-1:0]};

    // Stage A plus the side-band delay lines that keep every output aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            memAddress <= 16'(MAP_BASE);
            pix_d      <= '0;
            bright_d   <= '0;
            hs_d       <= '1;
            vs_d       <= '1;
        end else begin
            memAddress <= next_addr;
            pix_d      <= {pix_d[MEM_LAT-1:0], pixpos};
            bright_d   <= {bright_d[LAT-3:0], bright};
            hs_d       <= {hs_d[LAT-3:0], hsync_in};
            vs_d       <= {vs_d[LAT-3:0], vsync_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            glyphAddress <= '0;
        end else begin
            glyphAddress <= {memData[GLYPH_BITS-1:0], pix_d[MEM_LAT]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) pal[i] <= pal_rst(i);
        end else if (pal_we) begin
            pal[pal_idx] <= pal_data;
        end
    end

`ifdef TILE_BLINK_EN
    logic [5:0] frame_cnt;
    logic       vs_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            vs_prev   <= 1'b1;
        end else begin
            vs_prev <= vsync_in;
            if (vs_prev && !vsync_in) frame_cnt <= frame_cnt + 6'd1;
        end
    end

    always_comb begin
        pal_sel = pal[glyphData];
        if (glyphData == 4'hF && !frame_cnt[5]) pal_sel = pal[0];
    end
`else
    always_comb begin
        pal_sel = pal[glyphData];
    end
`endif

    // Stage C: a write on the same edge is not yet visible here
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb         <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else begin
            rgb         <= bright_d[LAT-2] ? pal_sel : 24'h0;
            VGA_HS      <= hs_d[LAT-2];
            VGA_VS      <= vs_d[LAT-2];
            VGA_BLANK_N <= bright_d[LAT-2];
        end
    end

    assign VGA_R = rgb[23:16];
    assign VGA_G = rgb[15:8];
    assign VGA_B = rgb[7:0];

endmodule

// File: tb/tb_tile_render_pipe.sv
// Directed bench for tile_render_pipe with default parameters.
// Blink checks follow TILE_BLINK_EN when it is defined for the build.
module tb_tile_render_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bright = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [15:0] hCount = '0;
    logic [15:0] vCount = '0;
    logic [15:0] memAddress;
    logic [15:0] memData = '0;
    logic [9:0]  glyphAddress;
    logic [3:0]  glyphData = '0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_idx = '0;
    logic [23:0] pal_data = '0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N;

    int n_cmp = 0;
    int n_err = 0;

    tile_render_pipe dut (
        .clk(clk), .reset(reset), .bright(bright),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hCount(hCount), .vCount(vCount),
        .memAddress(memAddress), .memData(memData),
        .glyphAddress(glyphAddress), .glyphData(glyphData),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic vs_pulse();
        vsync_in = 1'b0;
        tick();
        vsync_in = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] rgb();
        return {8'h0, VGA_R, VGA_G, VGA_B};
    endfunction

    initial begin
        tick(2);
        check("rst_mem", memAddress, 40000);
        check("rst_glyph", glyphAddress, 0);
        check("rst_rgb", rgb(), 0);
        check("rst_hs", VGA_HS, 1);
        check("rst_vs", VGA_VS, 1);
        check("rst_blank", VGA_BLANK_N, 0);

        reset = 1'b0;
        hCount = 16'd8;
        vCount = 16'd4;
        bright = 1'b1;
        memData = 16'd7;
        glyphData = 4'd3;
        tick();
        check("a_mem", memAddress, 40162);
        tick();
        check("a_glyph", glyphAddress, 112);
        tick(2);
        check("a_blank_early", VGA_BLANK_N, 0);
        check("a_rgb_early", rgb(), 0);
        tick();
        check("a_blank", VGA_BLANK_N, 1);
        check("a_rgb", rgb(), 32'h00A2E6);

        vCount = 16'd0;
        for (int h = 0; h < 16; h++) begin
            hCount = 16'(h);
            tick();
            check("sweep_mem", memAddress, 40000 + (h >> 2));
            if (h >= 2) check("sweep_glyph", glyphAddress, 112 + ((h - 2) & 3));
        end

        hCount = 16'hFFFF;
        vCount = 16'hFFFF;
        tick();
        check("wrap_mem", memAddress, 56223);

        bright = 1'b0;
        glyphData = 4'd2;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        tick();
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        tick(3);
        check("blk_hs_early", VGA_HS, 1);
        tick();
        check("blk_hs", VGA_HS, 0);
        check("blk_vs", VGA_VS, 0);
        check("blk_blank", VGA_BLANK_N, 0);
        check("blk_rgb", rgb(), 0);
        tick();
        check("blk_hs_end", VGA_HS, 1);

        bright = 1'b1;
        tick(5);
        check("pw_before", rgb(), 32'hFFFF00);
        pal_we = 1'b1;
        pal_idx = 4'd2;
        pal_data = 24'h123456;
        tick();
        pal_we = 1'b0;
        check("pw_same", rgb(), 32'hFFFF00);
        tick();
        check("pw_next", rgb(), 32'h123456);

        reset = 1'b1;
        pal_we = 1'b1;
        pal_idx = 4'd2;
        pal_data = 24'h111111;
        tick();
        check("mr_rgb", rgb(), 0);
        check("mr_hs", VGA_HS, 1);
        check("mr_vs", VGA_VS, 1);
        check("mr_blank", VGA_BLANK_N, 0);
        check("mr_mem", memAddress, 40000);
        check("mr_glyph", glyphAddress, 0);
        reset = 1'b0;
        pal_we = 1'b0;
        tick(4);
        check("mr_blank_early", VGA_BLANK_N, 0);
        tick();
        check("mr_blank_back", VGA_BLANK_N, 1);
        check("mr_pal_reset", rgb(), 32'hFFFF00);

        pal_we = 1'b1;
        pal_idx = 4'd15;
        pal_data = 24'hFF0000;
        tick();
        pal_we = 1'b0;
        glyphData = 4'd15;
        tick(6);
`ifdef TILE_BLINK_EN
        check("blink_f0", rgb(), 0);
        for (int i = 0; i < 31; i++) vs_pulse();
        tick(6);
        check("blink_f31", rgb(), 0);
        vs_pulse();
        tick(6);
        check("blink_f32", rgb(), 32'hFF0000);
        for (int i = 0; i < 32; i++) vs_pulse();
        tick(6);
        check("blink_f64", rgb(), 0);
`else
        check("idx15", rgb(), 32'hFF0000);
        for (int i = 0; i < 3; i++) vs_pulse();
        tick(6);
        check("idx15_steady", rgb(), 32'hFF0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
